vga_sync_gen: RTL and testbench
===============================

// Module: vga_sync_gen
// PURPOSE
//  Produces the HCount/VCount raster coordinates plus hsync, vsync and video_on for the VGA port.
//  All object renderers (shape ROM blocks) consume these as combinational pixel-on inputs.
//  Single clock domain. An internal pixel-tick divider derives the pixel rate from clk.
// PARAMETERS
//  PIX_DIV   2    clk cycles per pixel; >=1. 50 MHz / 2 = 25 MHz pixel rate.
//  H_DISP    640  visible pixels per line
//  H_FP      16   horizontal front porch, in pixels
//  H_SYNC    96   hsync pulse width, in pixels
//  H_BP      48   horizontal back porch; H_TOTAL = sum of all H_* = 800, must be <=1024
//  V_DISP    480  visible lines per frame
//  V_FP      10   vertical front porch, in lines
//  V_SYNC    2    vsync pulse width, in lines
//  V_BP      33   vertical back porch; V_TOTAL = sum of all V_* = 525, must be <=1024
//  SYNC_POL  0    active level of hsync and vsync (0 = active-low)
// PORTS
//  clk          in   1   system clock
//  reset        in   1   synchronous, active-high
//  HCount       out  10  current column, 0..H_TOTAL-1
//  VCount       out  10  current line, 0..V_TOTAL-1
//  hsync        out  1   horizontal sync to connector
//  vsync        out  1   vertical sync to connector
//  video_on     out  1   1 when HCount<H_DISP and VCount<V_DISP
//  pixel_tick   out  1   one-clk strobe; the counters advance on this cycle
//  frame_start  out  1   one-clk strobe; asserted on the tick that loads (0,0)
// BEHAVIOUR
//  - Reset, applied at a clk edge with reset=1 and effective mid-frame too:
//      HCount=0, VCount=0, hsync=vsync=~SYNC_POL, video_on=0, pixel_tick=0, frame_start=0.
//      Divider count=0.
//  - Divider:
//      Counts 0..PIX_DIV-1 on every clk.
//      pixel_tick=1 on the clk cycle where the count wraps to 0.
//      First tick occurs PIX_DIV clks after reset deasserts. PIX_DIV=1 gives pixel_tick held 1.
//  - Counters update only on cycles with pixel_tick=1:
//      HCount = (HCount==H_TOTAL-1) ? 0 : HCount+1.
//      VCount increments only when HCount wraps; VCount wraps to 0 at V_TOTAL-1.
//  - Output decode:
//      hsync, vsync and video_on are registered.
//      They are computed from the next counter values, so they align with HCount/VCount
//      in the same clk cycle, with zero relative latency.
//      Exception: immediately after reset, video_on=0 at (0,0) until the first tick.
//      The pixel (0,0) of the first frame is blanked. This is intended.
//  - Sync windows:
//      hsync = SYNC_POL while H_DISP+H_FP <= HCount < H_DISP+H_FP+H_SYNC (656..751).
//      vsync = SYNC_POL while V_DISP+V_FP <= VCount < V_DISP+V_FP+V_SYNC (490..491).
//      Both are ~SYNC_POL otherwise.
//  - frame_start:
//      Asserted together with pixel_tick when (HCount,VCount) transition (799,524) -> (0,0).
//      Not asserted on reset.
//  - Wrap corner: at (799,524) the H and V wraps occur on the same tick.
//      The next values are exactly (0,0), never (0,525).
//  - All outputs are glitch-free flops. Consumers may decode HCount/VCount combinationally.
// STRUCTURE
//  - Package vga_timing_pkg: the H_*/V_* defaults, H_TOTAL, V_TOTAL, COUNT_W=10,
//    and the derived constants H_SYNC_START/END and V_SYNC_START/END.
//  - Sub-module pixel_tick_gen: parameter PIX_DIV; ports clk, reset, pixel_tick.
//  - Top level holds the two counters, the next-state decode and the output registers.
// TESTING
//  1. Reset release, PIX_DIV=2 -> pixel_tick first seen 2 clks later, then every 2 clks;
//     HCount reaches 1 on the first tick.
//  2. Run one line -> hsync low exactly 96 ticks, covering HCount 656..751;
//     video_on=1 exactly for HCount 0..639 on visible lines.
//  3. Run a full frame -> 800*525 = 420000 ticks; vsync low only on VCount 490..491;
//     frame_start fires once, on the (799,524)->(0,0) tick.
//  4. Check at HCount=799, VCount=479 -> next tick gives (0,480), video_on=0
//     for the whole of line 480.
//  5. Assert reset for 1 clk at (300,200) -> next clk: (0,0), video_on=0, hsync=vsync=1;
//     counting restarts after PIX_DIV clks.
//  6. PIX_DIV=1, SYNC_POL=1 -> pixel_tick held 1, counters advance every clk,
//     hsync/vsync pulses are high.

Source files
------------

// File: rtl/vga_sync_gen_pkg.sv
// VGA raster timing defaults (640x480 @ 60 Hz) and small decode helpers.
package vga_timing_pkg;

   localparam int COUNT_W  = 10;
   localparam int PIX_DIV  = 2;

   localparam int H_DISP   = 640;
   localparam int H_FP     = 16;
   localparam int H_SYNC   = 96;
   localparam int H_BP     = 48;
   localparam int H_TOTAL  = H_DISP + H_FP + H_SYNC + H_BP;

   localparam int V_DISP   = 480;
   localparam int V_FP     = 10;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 33;
   localparam int V_TOTAL  = V_DISP + V_FP + V_SYNC + V_BP;

   // Sync windows are half-open: [START, END)
   localparam int H_SYNC_START = H_DISP + H_FP;
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
   localparam int V_SYNC_START = V_DISP + V_FP;
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

   localparam bit SYNC_POL = 1'b0;

   // True when lo <= val < hi
   function automatic logic in_window(input logic [COUNT_W-1:0] val, input int lo, input int hi);
      return (int'(val) >= lo) && (int'(val) < hi);
   endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Raster output bundle: counters, syncs and strobes seen by the renderers.
interface vga_sync_if #(
   parameter int W = vga_timing_pkg::COUNT_W
);
   logic [W-1:0] HCount;
   logic [W-1:0] VCount;
   logic         hsync;
   logic         vsync;
   logic         video_on;
   logic         pixel_tick;
   logic         frame_start;

   modport master (
      output HCount, VCount, hsync, vsync, video_on, pixel_tick, frame_start
   );

   modport slave (
      input  HCount, VCount, hsync, vsync, video_on, pixel_tick, frame_start
   );
endinterface

// File: rtl/vga_sync_gen_tick.sv
// Pixel-rate divider. pixel_tick is the advance enable for the coming clk edge:
// high in the cycle the divider count sits at PIX_DIV-1 (it wraps to 0 at that
// edge). The top flops it together with the counters so its own strobe lines up
// with the new coordinates.
module pixel_tick_gen #(
   parameter int PIX_DIV = 2
) (
   input  logic clk,
   input  logic reset,
   output logic pixel_tick
);

   localparam int            CW   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(PIX_DIV - 1);

   logic [CW-1:0] cnt;

   // Free-running 0..PIX_DIV-1 count; PIX_DIV=1 keeps it parked at 0
   always_ff @(posedge clk) begin
      if (reset)            cnt <= '0;
      else if (cnt == LAST) cnt <= '0;
      else                  cnt <= cnt + 1'b1;
   end

   assign pixel_tick = (cnt == LAST) && !reset;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster generator: H/V counters plus registered hsync, vsync, video_on,
// pixel_tick and frame_start. Decodes use the next counter values so every
// output changes on the same clk edge as HCount/VCount.
module vga_sync_gen
   import vga_timing_pkg::COUNT_W;
   import vga_timing_pkg::in_window;
#(
   parameter int PIX_DIV  = vga_timing_pkg::PIX_DIV,
   parameter int H_DISP   = vga_timing_pkg::H_DISP,
   parameter int H_FP     = vga_timing_pkg::H_FP,
   parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
   parameter int H_BP     = vga_timing_pkg::H_BP,
   parameter int V_DISP   = vga_timing_pkg::V_DISP,
   parameter int V_FP     = vga_timing_pkg::V_FP,
   parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
   parameter int V_BP     = vga_timing_pkg::V_BP,
   parameter bit SYNC_POL = vga_timing_pkg::SYNC_POL
) (
   input  logic       clk,
   input  logic       reset,
   vga_sync_if.master vga
);

   localparam int H_TOTAL  = H_DISP + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_DISP + V_FP + V_SYNC + V_BP;
   localparam int HS_START = H_DISP + H_FP;
   localparam int HS_END   = HS_START + H_SYNC;
   localparam int VS_START = V_DISP + V_FP;
   localparam int VS_END   = VS_START + V_SYNC;

   localparam logic [COUNT_W-1:0] H_LAST = COUNT_W'(H_TOTAL - 1);
   localparam logic [COUNT_W-1:0] V_LAST = COUNT_W'(V_TOTAL - 1);

   logic               adv;
   logic               h_wrap;
   logic               v_wrap;
   logic [COUNT_W-1:0] h_nxt;
   logic [COUNT_W-1:0] v_nxt;

   pixel_tick_gen #(.PIX_DIV(PIX_DIV)) u_tick (
      .clk        (clk),
      .reset      (reset),
      .pixel_tick (adv)
   );

   // Next raster position; H and V wrap on the same tick at the last pixel
   always_comb begin
      h_wrap = (vga.HCount == H_LAST);
      v_wrap = (vga.VCount == V_LAST);
      h_nxt  = h_wrap ? '0 : vga.HCount + 1'b1;
      v_nxt  = vga.VCount;
      if (h_wrap) v_nxt = v_wrap ? '0 : vga.VCount + 1'b1;
   end

   // Counters and decoded outputs, all loaded from the next position on a tick
   always_ff @(posedge clk) begin
      if (reset) begin
         vga.HCount      <= '0;
         vga.VCount      <= '0;
         vga.hsync       <= ~SYNC_POL;
         vga.vsync       <= ~SYNC_POL;
         vga.video_on    <= 1'b0;
         vga.pixel_tick  <= 1'b0;
         vga.frame_start <= 1'b0;
      end else begin
         vga.pixel_tick  <= adv;
         vga.frame_start <= adv && h_wrap && v_wrap;
         if (adv) begin
            vga.HCount   <= h_nxt;
            vga.VCount   <= v_nxt;
            vga.hsync    <= in_window(h_nxt, HS_START, HS_END) ? SYNC_POL : ~SYNC_POL;
            vga.vsync    <= in_window(v_nxt, VS_START, VS_END) ? SYNC_POL : ~SYNC_POL;
            vga.video_on <= (int'(h_nxt) < H_DISP) && (int'(v_nxt) < V_DISP);
         end
      end
   end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen. DUT A: default 640x480 timing, PIX_DIV=2, active-low
// syncs. DUT B: tiny 15x8 raster, PIX_DIV=1, active-high syncs, so a whole frame
// and the last-visible-line corner fit in a short run.
module tb_vga_sync_gen;

   typedef struct {
      logic [9:0] h;
      logic [9:0] v;
      logic       hs;
      logic       vs;
      logic       von;
      logic       fs;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_a = 1'b1;
   logic rst_b = 1'b1;

   always #5 clk = ~clk;

   vga_sync_if ia ();
   vga_sync_if ib ();

   vga_sync_gen #(.PIX_DIV(2)) dut_a (
      .clk   (clk),
      .reset (rst_a),
      .vga   (ia)
   );

   vga_sync_gen #(
      .PIX_DIV (1),
      .H_DISP  (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
      .V_DISP  (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
      .SYNC_POL(1'b1)
   ) dut_b (
      .clk   (clk),
      .reset (rst_b),
      .vga   (ib)
   );

   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb;
   int   n_cmp = 0;
   int   n_err = 0;
   int   phase = 0;
   int   hs_lo = 0;
   int   von1  = 0;
   int   fs_b  = 0;

   // Expected outputs on the k-th tick after reset (raster position k)
   function automatic exp_t mk(int k, int ht, int vt, int hd, int vd,
                               int hs0, int hs1, int vs0, int vs1, bit pol);
      exp_t e;
      int p, h, v;
      p     = k % (ht * vt);
      h     = p % ht;
      v     = p / ht;
      e.h   = 10'(h);
      e.v   = 10'(v);
      e.hs  = (h >= hs0 && h < hs1) ? pol : ~pol;
      e.vs  = (v >= vs0 && v < vs1) ? pol : ~pol;
      e.von = (h < hd) && (v < vd);
      e.fs  = (p == 0);
      return e;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic cmp_tick(input string nm, input exp_t e, input logic [9:0] h, input logic [9:0] v,
                           input logic hs, input logic vs, input logic von, input logic fs);
      n_cmp++;
      if ({h, v, hs, vs, von, fs} !== {e.h, e.v, e.hs, e.vs, e.von, e.fs}) begin
         n_err++;
         $display("FAIL %s: got (%0d,%0d) hs=%b vs=%b von=%b fs=%b expected (%0d,%0d) hs=%b vs=%b von=%b fs=%b",
                  nm, h, v, hs, vs, von, fs, e.h, e.v, e.hs, e.vs, e.von, e.fs);
      end
   endtask

   // clks from now until DUT A shows pixel_tick (bounded)
   task automatic meas_a(output int n);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!ia.pixel_tick && n < 20);
   endtask

   // Wait for a scoreboard queue to drain; timeout counts as a failed comparison
   task automatic wait_q(input bit sel_b, input int lim, input string nm);
      int g;
      g = 0;
      while (((sel_b ? qb.size() : qa.size()) != 0) && g < lim) begin
         @(posedge clk);
         g++;
      end
      if (g >= lim) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s: timeout, %0d expected ticks never seen", nm,
                  sel_b ? qb.size() : qa.size());
      end
   endtask

   // Monitor A: check every tick against the scoreboard, gather line statistics
   initial forever begin
      @(negedge clk);
      if (ia.pixel_tick) begin
         if (phase == 2) begin
            if (!ia.hsync && ia.VCount == 10'd0) hs_lo++;
            if (ia.video_on && ia.VCount == 10'd1) von1++;
         end
         if (qa.size() > 0) begin
            ea = qa.pop_front();
            cmp_tick("tick_a", ea, ia.HCount, ia.VCount, ia.hsync, ia.vsync, ia.video_on, ia.frame_start);
         end
      end
   end

   // Monitor B: same scoreboard check, plus frame_start occurrences
   initial forever begin
      @(negedge clk);
      if (ib.frame_start) fs_b++;
      if (ib.pixel_tick && qb.size() > 0) begin
         eb = qb.pop_front();
         cmp_tick("tick_b", eb, ib.HCount, ib.VCount, ib.hsync, ib.vsync, ib.video_on, ib.frame_start);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, notick;

      // Reset state of both DUTs
      repeat (3) @(posedge clk);
      #1;
      chk("rst_h",     int'(ia.HCount), 0);
      chk("rst_v",     int'(ia.VCount), 0);
      chk("rst_hs",    int'(ia.hsync), 1);
      chk("rst_vs",    int'(ia.vsync), 1);
      chk("rst_von",   int'(ia.video_on), 0);
      chk("rst_tick",  int'(ia.pixel_tick), 0);
      chk("rst_fs",    int'(ia.frame_start), 0);
      chk("rst_b_hs",  int'(ib.hsync), 0);
      chk("rst_b_vs",  int'(ib.vsync), 0);

      // A: release, tick cadence, run to (300,1)
      for (int k = 1; k <= 1100; k++) qa.push_back(mk(k, 800, 525, 640, 480, 656, 752, 490, 492, 1'b0));
      rst_a = 1'b0;
      meas_a(n);
      chk("first_tick_lat", n, 2);
      chk("first_tick_h", int'(ia.HCount), 1);
      meas_a(n);
      chk("tick_gap1", n, 2);
      meas_a(n);
      chk("tick_gap2", n, 2);
      wait_q(1'b0, 4000, "run_a1");
      #1;
      chk("pre_rst_h", int'(ia.HCount), 300);
      chk("pre_rst_v", int'(ia.VCount), 1);

      // A: one-clk reset mid-frame
      rst_a = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_h",   int'(ia.HCount), 0);
      chk("mid_rst_v",   int'(ia.VCount), 0);
      chk("mid_rst_von", int'(ia.video_on), 0);
      chk("mid_rst_hs",  int'(ia.hsync), 1);
      chk("mid_rst_vs",  int'(ia.vsync), 1);
      chk("mid_rst_fs",  int'(ia.frame_start), 0);
      phase = 2;
      for (int k = 1; k <= 1700; k++) qa.push_back(mk(k, 800, 525, 640, 480, 656, 752, 490, 492, 1'b0));
      rst_a = 1'b0;
      meas_a(n);
      chk("restart_lat", n, 2);
      wait_q(1'b0, 4000, "run_a2");
      phase = 3;
      chk("hsync_low_ticks", hs_lo, 96);
      chk("video_on_line1",  von1, 640);

      // B: full frame plus a few ticks, pixel_tick held high
      @(posedge clk); #1;
      for (int k = 1; k <= 130; k++) qb.push_back(mk(k, 15, 8, 8, 4, 10, 13, 5, 7, 1'b1));
      rst_b  = 1'b0;
      notick = 0;
      repeat (130) begin
         @(posedge clk); #1;
         if (!ib.pixel_tick) notick++;
      end
      chk("b_tick_held", notick, 0);
      wait_q(1'b1, 50, "run_b");
      chk("b_frame_start_cnt", fs_b, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
